upload_stream_scheduler: RTL and testbench

- Shares the single command-processor upload port between two requesters: the framed channel (arbiter output; whole AA44 frames) and the raw streaming channel (digital-capture passthrough).
- Replaces the combinational active-select mux.
- Switches owners only at legal boundaries: frame end for framed, any byte for stream.
- Bounds stream hogging with a burst quota, so framed traffic (UART/SPI/I2C/DSM replies) is never starved.

---
 rtl/upload_sched_pkg.sv | 22 ++
 rtl/upload_stream_scheduler_stats.sv | 30 +++
 rtl/upload_stream_scheduler.sv | 149 ++++++++++++++
 tb/tb_upload_stream_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upload_sched_pkg.sv
// Shared types and constants for the upload stream scheduler.
// State encoding, grant codes and the default stream source id.
package upload_sched_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GNT_FRAMED = 2'd1,
        GNT_STREAM = 2'd2,
        GAP        = 2'd3
    } sched_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_FR   = 2'b01;
    localparam logic [1:0] GNT_ST   = 2'b10;

    localparam logic [7:0] ID_DC_STREAM = 8'h0B;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/upload_stream_scheduler_stats.sv
// Saturating accepted-byte counters for the framed and stream channels.
// Only instantiated by upload_stream_scheduler when UPLOAD_SCHED_STATS_EN is defined.
module upload_sched_stats
    import upload_sched_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_framed_xfer,
    input  logic        i_stream_xfer,
    output logic [31:0] o_framed_bytes,
    output logic [31:0] o_stream_bytes
);

    logic [31:0] r_framed_bytes;
    logic [31:0] r_stream_bytes;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_framed_bytes <= '0;
            r_stream_bytes <= '0;
        end else begin
            if (i_framed_xfer) r_framed_bytes <= sat_inc(r_framed_bytes);
            if (i_stream_xfer) r_stream_bytes <= sat_inc(r_stream_bytes);
        end
    end

    assign o_framed_bytes = r_framed_bytes;
    assign o_stream_bytes = r_stream_bytes;

endmodule

// File: rtl/upload_stream_scheduler.sv
// Arbitrates the processor upload port between whole framed frames and a raw byte stream.
// Optional byte statistics are built only when UPLOAD_SCHED_STATS_EN is defined.
module upload_stream_scheduler
    import upload_sched_pkg::*;
#(
    parameter int unsigned STREAM_BURST_MAX = 256,
    parameter int unsigned GAP_CYCLES       = 1,
    parameter int unsigned FRAMED_TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        framed_req,
    input  logic [7:0]  framed_data,
    input  logic [7:0]  framed_source,
    input  logic        framed_valid,
    output logic        framed_ready,
    input  logic        stream_active,
    input  logic        stream_req,
    input  logic [7:0]  stream_data,
    input  logic [7:0]  stream_source,
    input  logic        stream_valid,
    output logic        stream_ready,
    output logic        out_req,
    output logic [7:0]  out_data,
    output logic [7:0]  out_source,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  grant,
    output logic        timeout_pulse,
    output logic [31:0] stat_framed_bytes,
    output logic [31:0] stat_stream_bytes
);

    sched_state_e r_state, w_state_next;
    logic [1:0]   r_grant, w_grant_next;
    logic         r_preempt;
    logic [31:0]  r_to_cnt, r_burst_cnt, r_gap_cnt;

    // Ownership is dropped combinationally during reset so no handshake can complete.
    logic w_own_fr, w_own_st, w_fr_xfer, w_st_xfer;
    logic w_arb_st, w_timeout, w_burst_hit, w_gap_done;

    assign w_own_fr  = (r_grant == GNT_FR) && !rst;
    assign w_own_st  = (r_grant == GNT_ST) && !rst;
    assign w_fr_xfer = w_own_fr && framed_valid && out_ready;
    assign w_st_xfer = w_own_st && stream_valid && out_ready;
    assign w_arb_st  = stream_active && stream_req;

    assign w_timeout   = (FRAMED_TIMEOUT != 32'd0) && (r_state == GNT_FRAMED) && !rst &&
                         framed_req && !w_fr_xfer && (r_to_cnt + 32'd1 == FRAMED_TIMEOUT);
    assign w_burst_hit = (r_state == GNT_STREAM) && framed_req && w_st_xfer &&
                         (r_burst_cnt + 32'd1 == STREAM_BURST_MAX);
    assign w_gap_done  = (r_gap_cnt == GAP_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= GNT_NONE;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_grant   <= w_grant_next;
            r_preempt <= (w_state_next == GAP) ? (r_preempt | w_burst_hit) : 1'b0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_arb_st)        w_state_next = GNT_STREAM;
                else if (framed_req) w_state_next = GNT_FRAMED;
            end
            GNT_FRAMED: begin
                if (!framed_req || w_timeout) w_state_next = GAP;
            end
            GNT_STREAM: begin
                if (w_burst_hit || !w_arb_st) w_state_next = GAP;
            end
            GAP: begin
                if (w_gap_done) begin
                    if (r_preempt && framed_req) w_state_next = GNT_FRAMED;
                    else if (w_arb_st)           w_state_next = GNT_STREAM;
                    else if (framed_req)         w_state_next = GNT_FRAMED;
                    else                         w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        w_grant_next = (w_state_next == GNT_FRAMED) ? GNT_FR :
                       (w_state_next == GNT_STREAM) ? GNT_ST : GNT_NONE;
    end

    always_comb begin
        out_req    = w_own_fr | w_own_st;
        out_data   = 8'h00;
        out_source = 8'h00;
        out_valid  = 1'b0;
        if (w_own_fr) begin
            out_data   = framed_data;
            out_source = framed_source;
            out_valid  = framed_valid;
        end else if (w_own_st) begin
            out_data   = stream_data;
            out_source = stream_source;
            out_valid  = stream_valid;
        end
        framed_ready  = w_own_fr & out_ready;
        stream_ready  = w_own_st & out_ready;
        timeout_pulse = w_timeout;
    end

    assign grant = r_grant;

    // Burst count survives stream re-grants so toggling stream_req cannot reset the quota.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt    <= '0;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
        end else begin
            if (r_state == GNT_FRAMED && w_state_next == GNT_FRAMED && !w_fr_xfer)
                r_to_cnt <= r_to_cnt + 32'd1;
            else
                r_to_cnt <= '0;

            if (!framed_req || r_state == GNT_FRAMED) r_burst_cnt <= '0;
            else if (w_st_xfer)                       r_burst_cnt <= r_burst_cnt + 32'd1;

            if (r_state == GAP && !w_gap_done) r_gap_cnt <= r_gap_cnt + 32'd1;
            else                               r_gap_cnt <= '0;
        end
    end

`ifdef UPLOAD_SCHED_STATS_EN
    upload_sched_stats u_stats (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_framed_xfer  (w_fr_xfer),
        .i_stream_xfer  (w_st_xfer),
        .o_framed_bytes (stat_framed_bytes),
        .o_stream_bytes (stat_stream_bytes)
    );
`else
    assign stat_framed_bytes = 32'd0;
    assign stat_stream_bytes = 32'd0;
`endif

endmodule

// File: tb/tb_upload_stream_scheduler.sv
// Scoreboard bench for upload_stream_scheduler: directed scenarios plus a random soak.
module tb_upload_stream_scheduler;
    import upload_sched_pkg::*;

    localparam int unsigned BURST = 4;
    localparam int unsigned GAPC  = 1;
    localparam int unsigned TMO   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        framed_req, framed_valid, framed_ready;
    logic [7:0]  framed_data, framed_source;
    logic        stream_active, stream_req, stream_valid, stream_ready;
    logic [7:0]  stream_data, stream_source;
    logic        out_req, out_valid, out_ready;
    logic [7:0]  out_data, out_source;
    logic [1:0]  grant;
    logic        timeout_pulse;
    logic [31:0] stat_framed_bytes, stat_stream_bytes;

    always #5 clk = ~clk;

    upload_stream_scheduler #(
        .STREAM_BURST_MAX (BURST),
        .GAP_CYCLES       (GAPC),
        .FRAMED_TIMEOUT   (TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .framed_req        (framed_req),
        .framed_data       (framed_data),
        .framed_source     (framed_source),
        .framed_valid      (framed_valid),
        .framed_ready      (framed_ready),
        .stream_active     (stream_active),
        .stream_req        (stream_req),
        .stream_data       (stream_data),
        .stream_source     (stream_source),
        .stream_valid      (stream_valid),
        .stream_ready      (stream_ready),
        .out_req           (out_req),
        .out_data          (out_data),
        .out_source        (out_source),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .grant             (grant),
        .timeout_pulse     (timeout_pulse),
        .stat_framed_bytes (stat_framed_bytes),
        .stat_stream_bytes (stat_stream_bytes)
    );

    int n_checks = 0;
    int n_err    = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: event occurred, expected none", name);
    endfunction

    // Source models and expected-output scoreboard queues ({source, data}).
    logic [7:0]  frame[$];
    logic [7:0]  frm_tmp[$];
    logic [7:0]  s_bytes[$];
    logic [15:0] exp_f[$];
    logic [15:0] exp_s[$];
    logic [7:0]  f_src;
    bit          f_on = 0;
    int          f_vp = 100, s_vp = 100, rp = 100, rdy_mode = 0;

    int          n_fr = 0, n_st = 0, run = 0;
    bit          fr_open = 0, log_en = 0;
    logic [1:0]  g_log[$];

    // Monitor: pops expected bytes on every accepted transfer and checks ordering rules.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) check("valid_needs_req", out_req, 1);
            if (framed_ready) check("fr_ready_owner", grant, GNT_FR);
            if (stream_ready) check("st_ready_owner", grant, GNT_ST);
            if (rst || !framed_req || grant == GNT_FR) run = 0;
            if (out_req && out_valid && out_ready) begin
                if (grant == GNT_FR) begin
                    if (exp_f.size() == 0) fail_now("framed_extra_byte");
                    else check("framed_byte", {out_source, out_data}, exp_f.pop_front());
                    fr_open = 1;
                    n_fr++;
                end else if (grant == GNT_ST) begin
                    if (exp_s.size() == 0) fail_now("stream_extra_byte");
                    else check("stream_byte", {out_source, out_data}, exp_s.pop_front());
                    check("frame_not_split", fr_open, 0);
                    if (framed_req) begin
                        run++;
                        check("burst_quota", run <= BURST, 1);
                    end
                    n_st++;
                end else begin
                    fail_now("xfer_without_grant");
                end
            end
            if (!framed_req || timeout_pulse || rst) fr_open = 0;
            if (log_en) g_log.push_back(grant);
        end
    end

    task automatic drive();
        if (f_on && frame.size() == 0) begin
            framed_req = 1'b0;
            f_on = 0;
        end
        framed_valid  = f_on && frame.size() > 0 && ($urandom_range(99) < f_vp);
        framed_data   = (frame.size() > 0) ? frame[0] : 8'h00;
        framed_source = f_src;
        stream_valid  = s_bytes.size() > 0 && ($urandom_range(99) < s_vp);
        stream_data   = (s_bytes.size() > 0) ? s_bytes[0] : 8'h00;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(99) < rp);
        endcase
    endtask

    task automatic tick();
        bit fa, sa;
        @(negedge clk);
        fa = framed_valid && framed_ready;
        sa = stream_valid && stream_ready;
        @(posedge clk);
        #1;
        if (fa) void'(frame.pop_front());
        if (sa) void'(s_bytes.pop_front());
        drive();
    endtask

    task automatic start_frame(input logic [7:0] src);
        f_src = src;
        foreach (frm_tmp[i]) begin
            frame.push_back(frm_tmp[i]);
            exp_f.push_back({src, frm_tmp[i]});
        end
        frm_tmp.delete();
        framed_req = 1'b1;
        f_on = 1;
        drive();
    endtask

    task automatic rand_frame(input int len);
        for (int i = 0; i < len; i++) frm_tmp.push_back(8'($urandom_range(255)));
    endtask

    task automatic push_stream(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(255));
            s_bytes.push_back(b);
            exp_s.push_back({ID_DC_STREAM, b});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] rg[$];
        int         rn[$];
        int         base;

        rst = 1'b1;
        framed_req = 0; framed_valid = 0; framed_data = 0; framed_source = 0;
        stream_active = 0; stream_req = 0; stream_valid = 0; stream_data = 0;
        stream_source = ID_DC_STREAM; out_ready = 1;
        tick();
        tick();
        check("rst_grant", grant, GNT_NONE);
        check("rst_out_req", out_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fr_ready", framed_ready, 0);
        check("rst_st_ready", stream_ready, 0);
        check("rst_timeout", timeout_pulse, 0);
        check("rst_stat_fr", stat_framed_bytes, 0);
        rst = 1'b0;
        tick();

        // Framed only, fixed frame.
        frm_tmp = '{8'hAA, 8'h44, 8'h01, 8'h00, 8'h02, 8'h55};
        base = n_fr;
        start_frame(8'h01);
        check("s1_req_latency0", out_req, 0);
        tick();
        check("s1_req_latency1", out_req, 1);
        check("s1_grant", grant, GNT_FR);
        for (int i = 0; i < 50 && f_on; i++) tick();
        check("s1_frame_done", f_on, 0);
        tick();
        check("s1_gap_req", out_req, 0);
        check("s1_gap_grant", grant, GNT_NONE);
        check("s1_bytes", n_fr - base, 6);

        // Simultaneous requests with a burst quota of BURST.
        do_reset();
        stream_active = 1;
        stream_req = 1;
        push_stream(12);
        rand_frame(6);
        log_en = 1;
        start_frame(8'h02);
        for (int i = 0; i < 30; i++) tick();
        log_en = 0;
        foreach (g_log[i]) begin
            if (rg.size() == 0) begin
                if (g_log[i] != GNT_NONE) begin rg.push_back(g_log[i]); rn.push_back(1); end
            end else if (g_log[i] == rg[rg.size()-1]) begin
                rn[rn.size()-1]++;
            end else begin
                rg.push_back(g_log[i]);
                rn.push_back(1);
            end
        end
        if (rg.size() < 5) begin
            fail_now("s2_run_sequence_short");
        end else begin
            check("s2_first_owner", rg[0], GNT_ST);
            check("s2_stream_burst", rn[0], BURST);
            check("s2_gap1", rg[1], GNT_NONE);
            check("s2_gap1_len", rn[1], GAPC);
            check("s2_framed_next", rg[2], GNT_FR);
            check("s2_framed_len", rn[2], 7);
            check("s2_gap2_len", rn[3], GAPC);
            check("s2_stream_resume", rg[4], GNT_ST);
        end
`ifdef UPLOAD_SCHED_STATS_EN
        check("s2_stat_framed", stat_framed_bytes, 6);
        check("s2_stat_stream_ge4", stat_stream_bytes >= 4, 1);
`else
        check("s2_stat_framed", stat_framed_bytes, 0);
        check("s2_stat_stream", stat_stream_bytes, 0);
`endif
        stream_req = 0;
        for (int i = 0; i < 4; i++) tick();

        // Backpressure during a frame with the stream also requesting.
        rdy_mode = 1;
        rand_frame(6);
        base = n_fr;
        start_frame(8'h03);
        for (int i = 0; i < 10 && grant != GNT_FR; i++) tick();
        check("s3_granted", grant, GNT_FR);
        stream_req = 1;
        push_stream(4);
        for (int i = 0; i < 60 && f_on; i++) tick();
        check("s3_frame_done", f_on, 0);
        check("s3_bytes", n_fr - base, 6);
        rdy_mode = 0;
        for (int i = 0; i < 40 && s_bytes.size() > 0; i++) tick();
        check("s3_stream_drained", s_bytes.size(), 0);
        stream_req = 0;
        for (int i = 0; i < 4; i++) tick();

        // Framed owner holding req without data is released after TMO cycles.
        check("s4_idle", grant, GNT_NONE);
        framed_req = 1;
        tick();
        check("s4_granted", grant, GNT_FR);
        stream_req = 1;
        for (int k = 1; k <= TMO; k++) begin
            check("s4_timeout_pulse", timeout_pulse, (k == TMO) ? 1 : 0);
            tick();
        end
        check("s4_release_grant", grant, GNT_NONE);
        check("s4_pulse_once", timeout_pulse, 0);
        tick();
        check("s4_stream_granted", grant, GNT_ST);
        framed_req = 0;
        stream_req = 0;
        for (int i = 0; i < 4; i++) tick();

        // Reset in the middle of a stream burst.
        stream_req = 1;
        push_stream(10);
        base = n_st;
        for (int i = 0; i < 20 && (n_st - base) < 3; i++) tick();
        rst = 1;
        tick();
        check("s5_rst_grant", grant, GNT_NONE);
        check("s5_rst_out_req", out_req, 0);
        check("s5_rst_out_valid", out_valid, 0);
        check("s5_rst_st_ready", stream_ready, 0);
        check("s5_bytes_before_rst", n_st - base, 3);
        rst = 0;
        tick();
        check("s5_regrant", grant, GNT_ST);
        for (int i = 0; i < 40 && s_bytes.size() > 0; i++) tick();
        stream_req = 0;
        for (int i = 0; i < 4; i++) tick();

        // Random soak.
        rdy_mode = 2; rp = 60; f_vp = 70; s_vp = 70;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!f_on && $urandom_range(19) == 0) begin
                rand_frame(1 + $urandom_range(7));
                start_frame(8'($urandom_range(255)));
            end
            if (s_bytes.size() < 32 && $urandom_range(9) == 0) push_stream(1 + $urandom_range(3));
            if ($urandom_range(19) == 0) stream_req = ~stream_req;
            if ($urandom_range(99) == 0) stream_active = ~stream_active;
        end
        rdy_mode = 0; f_vp = 100; s_vp = 100;
        stream_req = 1; stream_active = 1;
        for (int i = 0; i < 600 && (f_on || s_bytes.size() > 0); i++) tick();
        for (int i = 0; i < 4; i++) tick();
        check("soak_framed_drained", exp_f.size(), 0);
        check("soak_stream_drained", exp_s.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
